// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared branch types, sequencer states and datapath width
package cpu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BLT  = 3'b001;
  localparam logic [2:0] BR_BGT  = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b011;
  localparam logic [2:0] BR_JMP  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_OPS,
    ST_COMPARE,
    ST_REDIRECT,
    ST_FLUSH
  } br_state_e;

  // Conditional branches are the only types that need the comparator.
  function automatic logic is_cond(input logic [2:0] t);
    return (t == BR_BLT) || (t == BR_BGT) || (t == BR_BEQ);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment when enabled, sticking at all-ones.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - branch/jump front-end driving the external comparator
module branch_sequencer #(
  parameter int DATA_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_type,
  input  logic [DATA_W-1:0] br_target,
  input  logic              ops_ready,
  input  logic [DATA_W-1:0] op1_in,
  input  logic [DATA_W-1:0] r0_in,
  input  logic              kill,
  output logic [2:0]        cmp_ctrl,
  output logic [DATA_W-1:0] cmp_op1,
  output logic [DATA_W-1:0] cmp_r0,
  input  logic              cmp_pcsrc,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic              stall,
  output logic [15:0]       taken_count
);

  import cpu_pkg::*;

  // REDIRECT is the first flush cycle, so FLUSH holds for the remaining ones.
  localparam logic [3:0] FLUSH_INIT = 4'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  br_state_e         state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] r0_q, r0_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic              count_en;

  // Next-state, request/operand latching and outputs; kill overrides everything.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    target_d = target_q;
    op1_d    = op1_q;
    r0_d     = r0_q;
    fcnt_d   = fcnt_q;

    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_valid) begin
            type_d   = br_type;
            target_d = br_target;
            if (br_type == BR_JMP) begin
              state_d = ST_REDIRECT;
            end else if (is_cond(br_type)) begin
              if (ops_ready) begin
                op1_d   = op1_in;
                r0_d    = r0_in;
                state_d = ST_COMPARE;
              end else begin
                state_d = ST_WAIT_OPS;
              end
            end
          end
        end
        ST_WAIT_OPS: begin
          if (ops_ready) begin
            op1_d   = op1_in;
            r0_d    = r0_in;
            state_d = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          state_d = cmp_pcsrc ? ST_REDIRECT : ST_IDLE;
        end
        ST_REDIRECT: begin
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (fcnt_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    br_ready = (state_q == ST_IDLE);
    stall    = (state_q != ST_IDLE);
    cmp_ctrl = (state_q == ST_COMPARE) ? type_q : BR_NONE;
    pc_load  = (state_q == ST_REDIRECT);
    flush    = (state_q == ST_REDIRECT) || (state_q == ST_FLUSH);
    count_en = (state_q == ST_REDIRECT) && !kill;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      type_q   <= BR_NONE;
      target_q <= '0;
      op1_q    <= '0;
      r0_q     <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      target_q <= target_d;
      op1_q    <= op1_d;
      r0_q     <= r0_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign cmp_op1   = op1_q;
  assign cmp_r0    = r0_q;
  assign pc_target = target_q;

  sat_counter #(.W(16)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (count_en),
    .count (taken_count)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, ops_ready, kill;
  logic [2:0]  br_type;
  logic [15:0] br_target, op1_in, r0_in;
  logic        br_ready, cmp_pcsrc, pc_load, flush, stall;
  logic [2:0]  cmp_ctrl;
  logic [15:0] cmp_op1, cmp_r0, pc_target, taken_count;

  logic        b1_valid;
  logic [2:0]  b1_type;
  logic [15:0] b1_target;
  logic        b1_ready, b1_pc_load, b1_flush, b1_stall;
  logic [2:0]  b1_cmp_ctrl;
  logic [15:0] b1_cmp_op1, b1_cmp_r0, b1_pc_target, b1_count;

  always #5 clk = ~clk;

  branch_sequencer #(.DATA_W(16), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_type(br_type), .br_target(br_target), .ops_ready(ops_ready),
    .op1_in(op1_in), .r0_in(r0_in), .kill(kill), .cmp_ctrl(cmp_ctrl),
    .cmp_op1(cmp_op1), .cmp_r0(cmp_r0), .cmp_pcsrc(cmp_pcsrc),
    .pc_load(pc_load), .pc_target(pc_target), .flush(flush), .stall(stall),
    .taken_count(taken_count)
  );

  branch_sequencer #(.DATA_W(16), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .br_valid(b1_valid), .br_ready(b1_ready),
    .br_type(b1_type), .br_target(b1_target), .ops_ready(1'b0),
    .op1_in(16'h0000), .r0_in(16'h0000), .kill(1'b0), .cmp_ctrl(b1_cmp_ctrl),
    .cmp_op1(b1_cmp_op1), .cmp_r0(b1_cmp_r0), .cmp_pcsrc(1'b0),
    .pc_load(b1_pc_load), .pc_target(b1_pc_target), .flush(b1_flush),
    .stall(b1_stall), .taken_count(b1_count)
  );

  // Unsigned comparator model: the result the branch should take.
  function automatic logic cmp_ref(input logic [2:0] t, input logic [15:0] a, input logic [15:0] b);
    case (t)
      3'b001:  return a < b;
      3'b010:  return a > b;
      3'b011:  return a == b;
      default: return 1'b0;
    endcase
  endfunction

  assign cmp_pcsrc = cmp_ref(cmp_ctrl, cmp_op1, cmp_r0);

  typedef struct { int cyc; logic [2:0] t; logic [15:0] a; logic [15:0] b; } cmp_t;
  typedef struct { int cyc; logic [15:0] tgt; int flen; logic [15:0] cnt; } red_t;

  cmp_t        cq[$];
  red_t        rq[$];
  cmp_t        ce;
  red_t        re;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          flush_left = 0;
  logic        cnt_chk = 1'b0;
  logic [15:0] cnt_exp = 16'h0;
  logic [15:0] mcnt = 16'h0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'h1;
  endfunction

  // Monitor: pops expectations whenever the DUT shows a compare or a redirect.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("stall_vs_ready", stall, !br_ready);
      if (cnt_chk) begin
        chk("taken_count", taken_count, cnt_exp);
        cnt_chk = 1'b0;
      end
      if (cmp_ctrl != 3'b000) begin
        if (cq.size() == 0) chk("unexpected_cmp", cmp_ctrl, 0);
        else begin
          ce = cq.pop_front();
          chk("cmp_cycle", cyc, ce.cyc);
          chk("cmp_ctrl", cmp_ctrl, ce.t);
          chk("cmp_op1", cmp_op1, ce.a);
          chk("cmp_r0", cmp_r0, ce.b);
        end
      end
      if (pc_load) begin
        if (rq.size() == 0) chk("unexpected_pc_load", 1, 0);
        else begin
          re = rq.pop_front();
          chk("pc_load_cycle", cyc, re.cyc);
          chk("pc_target", pc_target, re.tgt);
          chk("flush_at_load", flush, 1);
          flush_left = re.flen - 1;
          cnt_chk = 1'b1;
          cnt_exp = re.cnt;
        end
      end else if (flush_left > 0) begin
        chk("flush_hold", flush, 1);
        flush_left--;
      end else begin
        chk("flush_idle", flush, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!br_ready && n < 20) begin step(); n++; end
    if (!br_ready) chk("ready_timeout", 0, 1);
  endtask

  // mode: 0 plain, 1 kill with request in IDLE, 2 kill in last WAIT_OPS cycle,
  // 3 kill in COMPARE, 4 kill in REDIRECT.
  task automatic do_req(input logic [2:0] t, input int w_in, input int mode_in,
                        input logic [15:0] tg, input logic [15:0] a, input logic [15:0] b);
    int c, w, mode;
    logic cond, taken;
    w = w_in;
    mode = mode_in;
    cond = (t == 3'b001) || (t == 3'b010) || (t == 3'b011);
    if (mode == 2 && (w == 0 || !cond)) mode = 0;
    wait_ready();
    c = cyc;
    br_valid = 1'b1; br_type = t; br_target = tg; kill = (mode == 1);
    ops_ready = (w == 0);
    op1_in = (w == 0) ? a : 16'($urandom);
    r0_in  = (w == 0) ? b : 16'($urandom);
    step();
    br_valid = 1'b0; br_type = 3'($urandom); br_target = 16'($urandom);
    kill = 1'b0; ops_ready = 1'b0;
    if (mode == 1) begin
      chk("kill_idle_not_accepted", br_ready, 1);
      return;
    end
    if (t == 3'b100) begin
      rq.push_back('{c + 1, tg, (mode == 4) ? 1 : 2, (mode == 4) ? mcnt : sat_inc(mcnt)});
      if (mode != 4) mcnt = sat_inc(mcnt);
      if (mode == 4) begin kill = 1'b1; step(); kill = 1'b0; end
      return;
    end
    if (!cond) begin
      chk("dropped_ready", br_ready, 1);
      return;
    end
    if (w > 0) begin
      for (int i = 1; i < w; i++) begin
        op1_in = 16'($urandom); r0_in = 16'($urandom);
        step();
      end
      ops_ready = 1'b1; op1_in = a; r0_in = b; kill = (mode == 2);
      if (mode != 2) cq.push_back('{c + w + 1, t, a, b});
      step();
      ops_ready = 1'b0; kill = 1'b0;
      op1_in = 16'($urandom); r0_in = 16'($urandom);
      if (mode == 2) begin
        chk("kill_wait_idle", br_ready, 1);
        return;
      end
    end else begin
      cq.push_back('{c + 1, t, a, b});
    end
    taken = cmp_ref(t, a, b) && (mode != 3);
    kill = (mode == 3);
    if (taken) begin
      rq.push_back('{cyc + 1, tg, (mode == 4) ? 1 : 2, (mode == 4) ? mcnt : sat_inc(mcnt)});
      if (mode != 4) mcnt = sat_inc(mcnt);
    end
    step();
    kill = 1'b0;
    if (!taken) chk("not_taken_idle", br_ready, 1);
    else if (mode == 4) begin kill = 1'b1; step(); kill = 1'b0; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int r, w, m;
    logic [2:0] t;
    logic [15:0] a;
    rst_n = 1'b0; br_valid = 1'b0; br_type = 3'b000; br_target = 16'h0;
    ops_ready = 1'b0; op1_in = 16'h0; r0_in = 16'h0; kill = 1'b0;
    b1_valid = 1'b0; b1_type = 3'b000; b1_target = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_br_ready", br_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_cmp_ctrl", cmp_ctrl, 0);
    chk("rst_cmp_ops", {cmp_op1, cmp_r0}, 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_count", taken_count, 0);
    chk("rst1_outs", {b1_cmp_ctrl, b1_cmp_op1, b1_cmp_r0, b1_stall}, 0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    do_req(3'b011, 0, 0, 16'h0040, 16'h0005, 16'h0005);
    do_req(3'b001, 0, 0, 16'h0100, 16'h8000, 16'h0001);
    do_req(3'b010, 3, 0, 16'h0200, 16'h0009, 16'h0003);
    do_req(3'b100, 0, 0, 16'h0300, 16'h0, 16'h0);
    do_req(3'b010, 2, 2, 16'h0400, 16'h0009, 16'h0003);
    do_req(3'b011, 0, 1, 16'h0500, 16'h0007, 16'h0007);
    do_req(3'b000, 0, 0, 16'h0600, 16'h0, 16'h0);
    do_req(3'b110, 0, 0, 16'h0700, 16'h0, 16'h0);
    do_req(3'b100, 0, 4, 16'h0800, 16'h0, 16'h0);
    do_req(3'b011, 1, 3, 16'h0900, 16'h0001, 16'h0001);

    b1_valid = 1'b1; b1_type = 3'b100; b1_target = 16'h1234;
    step();
    b1_valid = 1'b0;
    chk("j1_pc_load", b1_pc_load, 1);
    chk("j1_pc_target", b1_pc_target, 16'h1234);
    chk("j1_flush", b1_flush, 1);
    chk("j1_ready_busy", b1_ready, 0);
    step();
    chk("j1_flush_done", b1_flush, 0);
    chk("j1_pc_load_done", b1_pc_load, 0);
    chk("j1_ready_back", b1_ready, 1);
    chk("j1_count", b1_count, 1);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) t = 3'(1 + r % 3);
      else if (r == 6) t = 3'b100;
      else t = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      m = $urandom_range(0, 11);
      m = (m > 4) ? 0 : m;
      a = 16'($urandom);
      do_req(t, w, m, 16'($urandom), a, ($urandom_range(0, 3) == 0) ? a : 16'($urandom));
    end

    wait_ready();
    step();
    force dut.u_taken_cnt.count_q = 16'hFFFE;
    #1;
    release dut.u_taken_cnt.count_q;
    mcnt = 16'hFFFE;
    do_req(3'b100, 0, 0, 16'hA000, 16'h0, 16'h0);
    do_req(3'b100, 0, 0, 16'hA001, 16'h0, 16'h0);
    wait_ready();
    step();
    chk("sat_count", taken_count, 16'hFFFF);

    mon_en = 1'b0;
    br_valid = 1'b1; br_type = 3'b100; br_target = 16'h55AA;
    step();
    br_valid = 1'b0;
    step();
    chk("pre_reset_flush", flush, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_br_ready", br_ready, 1);
    chk("midrst_flush", flush, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_pc_load", pc_load, 0);
    chk("midrst_pc_target", pc_target, 0);
    chk("midrst_count", taken_count, 0);
    chk("cmp_queue_drained", cq.size(), 0);
    chk("red_queue_drained", rq.size(), 0);
    step();
    rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Control front-end for the 16-bit branch comparator in the cosmic processing unit.
- Accepts one branch or jump request at a time from decode and holds the operands stable until they are valid.
- Drives the comparator's 3-bit control and operand inputs for exactly one cycle, samples its PCSrc result, then issues a PC redirect and pipeline flush.
- Stalls the front end while a branch is in flight and keeps a saturating taken-branch counter.

Parameters:
- DATA_W, 16, operand and PC width.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br_valid  in  1  decode presents a request.
- br_ready  out  1  sequencer can accept a request.
- br_type  in  3  000 none, 001 BLT, 010 BGT, 011 BEQ, 100 jump, 101-111 illegal.
- br_target  in  DATA_W  redirect address.
- ops_ready  in  1  hazard unit: op1_in/r0_in are valid this cycle.
- op1_in  in  DATA_W  branch operand.
- r0_in  in  DATA_W  compare reference (R0).
- kill  in  1  synchronous abort (exception/interrupt).
- cmp_ctrl  out  3  comparator control.
- cmp_op1  out  DATA_W  comparator op1.
- cmp_r0  out  DATA_W  comparator r0.
- cmp_pcsrc  in  1  comparator result, combinational from cmp_*.
- pc_load  out  1  one-cycle PC load strobe.
- pc_target  out  DATA_W  PC value to load.
- flush  out  1  squash younger pipeline stages.
- stall  out  1  hold fetch/decode.
- taken_count  out  16  saturating count of redirects.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE; every output 0 except br_ready=1; all internal registers 0.
- States: IDLE, WAIT_OPS, COMPARE, REDIRECT, FLUSH.
- br_ready is 1 only in IDLE. A request is accepted when br_valid && br_ready && !kill; accepting latches type and target.
- Accept of type 000 or 101-111: request is dropped, state stays IDLE. No redirect and no count.
- Accept of 100 (jump): go to REDIRECT next cycle; operands are ignored.
- Accept of 001/010/011:
  - ops_ready=1 in the same cycle: latch op1_in/r0_in, go to COMPARE.
  - ops_ready=0: go to WAIT_OPS.
- WAIT_OPS: on ops_ready, latch operands and go to COMPARE; otherwise stay.
- COMPARE (exactly 1 cycle):
  - cmp_ctrl = latched type; cmp_op1/cmp_r0 = latched operands.
  - cmp_pcsrc is sampled at the end of the cycle: 1 goes to REDIRECT, 0 goes to IDLE.
  - Comparison is unsigned (comparator semantics).
- Outside COMPARE: cmp_ctrl = 000. cmp_op1/cmp_r0 hold their last latched values.
- REDIRECT (1 cycle):
  - pc_load = 1, pc_target = latched target, flush = 1.
  - taken_count increments, saturating at 0xFFFF.
  - Next state is FLUSH if FLUSH_CYCLES>1, else IDLE.
- FLUSH: flush = 1; a down-counter gives FLUSH_CYCLES total flush cycles including REDIRECT, then IDLE.
- stall = 1 in every state except IDLE. It is registered from the state, so it has no combinational path from br_valid.
- pc_target holds its value after pc_load drops and is only meaningful while pc_load=1.
- Latency, accept to pc_load:
  - jump: 1 cycle.
  - conditional branch with ops ready: 2 cycles.
  - each WAIT_OPS cycle adds 1.
- kill has priority over everything. From any state it goes to IDLE next cycle: pending branch discarded, no pc_load, flush deasserted, taken_count unchanged. kill in the REDIRECT cycle suppresses that cycle's count increment but not the already-visible pc_load.
- Simultaneous kill and br_valid in IDLE: request not accepted.
- Reset mid-operation: immediate return to reset values; no partial redirect is completed.

Decomposition:
- Shared package cpu_pkg holds:
  - BR_NONE=3'b000, BR_BLT=3'b001, BR_BGT=3'b010, BR_BEQ=3'b011, BR_JMP=3'b100.
  - The state enum.
  - DATA_W.
- The comparator stays a separate instance outside this block.
- One natural sub-module: sat_counter (16-bit saturating increment with enable), reusable for other performance counters.

Test Plan:
1. BEQ, op1=0x0005, r0=0x0005, target=0x0040, ops_ready=1 -> cmp_ctrl=011 for one cycle, pc_load=1 with pc_target=0x0040 two cycles after accept, flush high 2 cycles, taken_count=1.
2. BLT, op1=0x8000, r0=0x0001 -> not taken (unsigned), back to IDLE after COMPARE, no pc_load, stall high exactly 1 cycle.
3. BGT, op1=0x0009, r0=0x0003, ops_ready low 3 cycles after accept -> 3 WAIT_OPS cycles, operands latched on the ops_ready cycle, pc_load 5 cycles after accept.
4. Jump, target=0x1234, FLUSH_CYCLES=1 -> pc_load 1 cycle after accept, flush 1 cycle, br_ready=1 the following cycle.
5. kill asserted during WAIT_OPS, and separately with br_valid in IDLE -> IDLE next cycle, no pc_load, no count change, request not accepted.
6. Preload via 0xFFFF taken jumps (or force), then one more jump -> taken_count stays 0xFFFF. rst_n low mid-FLUSH -> all outputs at reset values immediately.
